fp_addsub_sched: RTL and testbench
==================================

FP_ADDSUB_SCHED -- requirements
Module: fp_addsub_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one pipelined 128-bit add/subtract unit.
REQ-002 Parameter LAT, default 13, fixed latency in ce-enabled clocks from operand issue to result at fpu_o.
REQ-003 Parameter OWID, default $bits(FP128X), width of the unit's result bus.
REQ-004 Port clk, input, 1, system clock; all state updates on posedge clk.
REQ-005 Port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 Port req_vld, input, NREQ, requester i has an operation pending.
REQ-007 Port req_rdy, output, NREQ, one-hot or zero grant; the operation is accepted when req_vld[i] & req_rdy[i].
REQ-008 Ports req_a / req_b, input, NREQ*128, packed operands; slice i belongs to requester i.
REQ-009 Ports req_op / req_rm, input, NREQ*1 / NREQ*3, per-requester add(0)/sub(1) and rounding mode.
REQ-010 Ports fpu_ce / fpu_op / fpu_rm / fpu_a / fpu_b, output, 1/1/3/128/128, drive the shared unit.
REQ-011 Port fpu_o, input, OWID, result from the shared unit.
REQ-012 Port rsp_vld, output, NREQ, one-hot or zero result strobe to requester i.
REQ-013 Port rsp_rdy, input, NREQ, requester i can take a result this cycle.
REQ-014 Port rsp_data, output, OWID, result bus shared by all requesters; equals fpu_o.
REQ-015 Port inflight, output, clog2(LAT+1), count of valid tags in the pipeline.

Function
REQ-016 Tag pipeline: LAT stages of {vld, id[clog2(NREQ)-1:0]}; shifts one stage per clock only when fpu_ce=1; stage 0 loads {accept, granted id}.
REQ-017 Output stage LAT-1 is aligned with fpu_o; rsp_vld[id]=stage vld, all other bits 0.
REQ-018 Stall: fpu_ce = ~(tag[LAT-1].vld & ~rsp_rdy[tag[LAT-1].id]); the whole unit and tag pipe freeze while a result is held.
REQ-019 While stalled, req_rdy=0; rsp_vld and rsp_data stay stable until rsp_rdy is seen.
REQ-020 Arbitration: round-robin starting from pointer ptr; grant = first i with req_vld[i], searching ptr, ptr+1, ... modulo NREQ; combinational, one grant per cycle.
REQ-021 On accept, ptr <= granted id + 1 modulo NREQ; with no accept, ptr holds.
REQ-022 fpu_a/b/op/rm = granted requester's slices; with no grant they are 0 and the stage-0 tag is invalid (bubble).
REQ-023 Throughput: one accept per unstalled cycle; back-to-back issue from the same requester is allowed when it is the only one requesting.
REQ-024 inflight = number of valid tags; an accept and a retire in the same cycle leave it unchanged.
REQ-025 Ordering: results return in issue order; the block neither reorders nor drops results.
REQ-026 A retire and a new accept in the same unstalled cycle are both permitted.
REQ-027 req_vld may drop without acceptance; there is no commitment until accepted.
REQ-028 Requester stall on rsp_rdy=0 blocks all requesters (head-of-line); intended behaviour.

Reset
REQ-029 rst_n low immediately clears all tag vld bits, ptr=0 and inflight=0; rsp_vld=0, req_rdy=0 while asserted.
REQ-030 Reset mid-operation discards in-flight results; after release, data still emerging from the unit is ignored because its tags are invalid.
REQ-031 First grant is possible in the first clock after rst_n deasserts.

Verification
REQ-032 Single op: req_vld=0001 at cycle 0, rsp_rdy=all 1 -> req_rdy=0001 at cycle 0, rsp_vld=0001 at cycle 13, rsp_data=fpu_o, inflight=1 during cycles 1-13.
REQ-033 All four requesting continuously, ptr=0 -> grants 0,1,2,3,0,... on consecutive cycles; rsp_vld follows the same order starting at cycle 13.
REQ-034 Stall: result for req 2 at head with rsp_rdy[2]=0 for 5 cycles -> fpu_ce=0, req_rdy=0, rsp_vld=0100 held 5 cycles; released on rsp_rdy[2]=1, no result lost or duplicated.
REQ-035 Reset mid-stream: 6 ops in flight, rst_n pulsed low -> inflight=0 and rsp_vld=0 immediately; no rsp_vld for 13 cycles after release without new accepts.
REQ-036 Sparse: req 3 only, then req 1 one cycle later -> grants 3 then 1; ptr=2 after the second accept.
REQ-037 Random stimulus with a scoreboard: every accepted op produces exactly one rsp_vld to its issuer, in order, with inflight ≤ LAT.

Source files
------------

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: round-robin scheduler that shares one pipelined 128-bit FP add/sub
// unit among NREQ requesters; a tag pipe tracks each result back to its issuer.
package fp_addsub_sched_pkg;
  typedef struct packed {
    logic         sign;
    logic [14:0]  exp;
    logic [111:0] man;
  } FP128X;
endpackage

module fp_addsub_sched
  import fp_addsub_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 13,
  parameter int OWID = $bits(FP128X)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_vld,
  output logic [NREQ-1:0]             req_rdy,
  input  logic [NREQ*128-1:0]         req_a,
  input  logic [NREQ*128-1:0]         req_b,
  input  logic [NREQ-1:0]             req_op,
  input  logic [NREQ*3-1:0]           req_rm,
  output logic                        fpu_ce,
  output logic                        fpu_op,
  output logic [2:0]                  fpu_rm,
  output logic [127:0]                fpu_a,
  output logic [127:0]                fpu_b,
  input  logic [OWID-1:0]             fpu_o,
  output logic [NREQ-1:0]             rsp_vld,
  input  logic [NREQ-1:0]             rsp_rdy,
  output logic [OWID-1:0]             rsp_data,
  output logic [$clog2(LAT+1)-1:0]    inflight
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshakes: a transfer happens on a cycle where both vld and rdy are high.
  // req_rdy is combinational from req_vld (one-hot grant); rsp_vld is registered
  // and, once raised, holds with stable rsp_data until the matching rsp_rdy.

  logic [IDW-1:0] ptr;
  logic           tag_vld [LAT];
  logic [IDW-1:0] tag_id  [LAT];

  logic           head_vld;
  logic [IDW-1:0] head_id;
  logic           grant_vld;
  logic [IDW-1:0] grant_id;
  logic           retire;
  int             cand_int;
  logic [IDW-1:0] cand;

  assign head_vld = tag_vld[LAT-1];
  assign head_id  = tag_id[LAT-1];

  // A held result freezes the unit and the tag pipe together so they stay aligned.
  assign fpu_ce   = ~(head_vld & ~rsp_rdy[head_id]);
  assign retire   = head_vld & fpu_ce;
  assign rsp_data = fpu_o;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand_int  = 0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_int = int'(ptr) + k;
      if (cand_int >= NREQ) cand_int = cand_int - NREQ;
      cand = IDW'(cand_int);
      if (!grant_vld && req_vld[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (!(fpu_ce && rst_n)) grant_vld = 1'b0;
  end

  always_comb begin
    req_rdy = '0;
    fpu_a   = '0;
    fpu_b   = '0;
    fpu_op  = 1'b0;
    fpu_rm  = '0;
    if (grant_vld) begin
      req_rdy[grant_id] = 1'b1;
      fpu_a  = req_a[int'(grant_id)*128 +: 128];
      fpu_b  = req_b[int'(grant_id)*128 +: 128];
      fpu_op = req_op[grant_id];
      fpu_rm = req_rm[int'(grant_id)*3 +: 3];
    end
  end

  always_comb begin
    rsp_vld = '0;
    if (head_vld) rsp_vld[head_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      inflight <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_id[i]  <= '0;
      end
    end else if (fpu_ce) begin
      tag_vld[0] <= grant_vld;
      tag_id[0]  <= grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      if (grant_vld) ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
      if (grant_vld && !retire)      inflight <= inflight + 1'b1;
      else if (!grant_vld && retire) inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: stand-in LAT-stage adder, queue-based reference model
// checked every cycle, and directed vectors with hand-computed expectations.
module tb_fp_addsub_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 13;
  localparam int OWID = 128;
  localparam int CW   = $clog2(LAT + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_vld, req_rdy, req_op, rsp_vld, rsp_rdy;
  logic [NREQ*128-1:0] req_a, req_b;
  logic [NREQ*3-1:0]   req_rm;
  logic                fpu_ce, fpu_op;
  logic [2:0]          fpu_rm;
  logic [127:0]        fpu_a, fpu_b;
  logic [OWID-1:0]     fpu_o, rsp_data;
  logic [CW-1:0]       inflight;

  int n_chk = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  fp_addsub_sched #(.NREQ(NREQ), .LAT(LAT), .OWID(OWID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_rm(req_rm),
    .fpu_ce(fpu_ce), .fpu_op(fpu_op), .fpu_rm(fpu_rm), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_o(fpu_o),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .inflight(inflight)
  );

  // stand-in for the shared unit: integer add/sub with LAT ce-gated stages, never reset
  logic [127:0] unit_pipe [LAT];
  initial for (int i = 0; i < LAT; i++) unit_pipe[i] = '0;
  always @(posedge clk) begin
    if (fpu_ce) begin
      unit_pipe[0] <= fpu_op ? fpu_a - fpu_b : fpu_a + fpu_b;
      for (int i = 1; i < LAT; i++) unit_pipe[i] <= unit_pipe[i-1];
    end
  end
  assign fpu_o = unit_pipe[LAT-1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: each accepted op is queued with the ce-count at issue; it is due
  // at the response port after exactly LAT enabled clocks
  typedef struct {
    int           id;
    logic [127:0] res;
    int           t;
  } ent_t;
  ent_t            exp_q[$];
  int              m_ptr = 0;
  int              m_ce  = 0;
  int              g;
  int              idx;
  bit              head_ready;
  bit              stall;
  logic [NREQ-1:0] exp_rsp, exp_rdy;
  logic [127:0]    ea, eb, eres;
  logic            eop;
  logic [2:0]      erm;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0;
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_inflight", inflight, 0);
    end else begin
      head_ready = (exp_q.size() > 0) && (m_ce - exp_q[0].t == LAT);
      exp_rsp = '0;
      stall   = 1'b0;
      if (head_ready) begin
        exp_rsp[exp_q[0].id] = 1'b1;
        stall = !rsp_rdy[exp_q[0].id];
      end
      g = -1;
      if (!stall) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_vld[idx]) g = idx;
        end
      end
      exp_rdy = '0;
      ea = '0; eb = '0; eop = 1'b0; erm = '0; eres = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea   = req_a[g*128 +: 128];
        eb   = req_b[g*128 +: 128];
        eop  = req_op[g];
        erm  = req_rm[g*3 +: 3];
        eres = eop ? ea - eb : ea + eb;
      end
      chk("rsp_vld", rsp_vld, exp_rsp);
      chk("req_rdy", req_rdy, exp_rdy);
      chk("fpu_ce", fpu_ce, !stall);
      chk("inflight", inflight, exp_q.size());
      chk("inflight_le_lat", inflight <= LAT, 1'b1);
      chk("fpu_a", fpu_a, ea);
      chk("fpu_b", fpu_b, eb);
      chk("fpu_op", fpu_op, eop);
      chk("fpu_rm", fpu_rm, erm);
      if (head_ready) chk("rsp_data", rsp_data, exp_q[0].res);
      if (!stall) begin
        if (head_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
          exp_q.push_back(ent_t'{id: g, res: eres, t: m_ce});
          m_ptr = (g + 1) % NREQ;
        end
        m_ce++;
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [127:0] a, input logic [127:0] b,
                        input logic op, input logic [2:0] rm);
    req_a[i*128 +: 128] = a;
    req_b[i*128 +: 128] = b;
    req_op[i]           = op;
    req_rm[i*3 +: 3]    = rm;
  endtask

  task automatic drain();
    int n;
    n = 0;
    next_cycle();
    req_vld = '0;
    rsp_rdy = '1;
    while (exp_q.size() > 0 && n < 100) begin
      next_cycle();
      n++;
    end
    chk("drain_done", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    rsp_rdy = '1;
    req_a   = '0;
    req_b   = '0;
    req_op  = '0;
    req_rm  = '0;
    repeat (2) sample();
    chk("reset_inflight", inflight, 0);
    chk("reset_rsp_vld", rsp_vld, 0);

    // single op, grant in the first clock after release
    next_cycle();
    rst_n = 1'b1;
    set_op(0, 128'd5, 128'd3, 1'b0, 3'b010);
    req_vld = 4'b0001;
    sample();
    chk("t1_rdy_c0", req_rdy, 4'b0001);
    chk("t1_fpu_a", fpu_a, 128'd5);
    chk("t1_fpu_rm", fpu_rm, 3'b010);
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      req_vld = '0;
      sample();
      chk("t1_inflight", inflight, (c <= 13) ? 1 : 0);
      chk("t1_rsp_vld", rsp_vld, (c == 13) ? 4'b0001 : 4'b0000);
      if (c == 13) chk("t1_rsp_data", rsp_data, 128'd8);
    end
    drain();

    // reset to ptr=0, then all four request continuously
    rst_n = 1'b0;
    sample();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) next_cycle();
      for (int i = 0; i < NREQ; i++) set_op(i, 128'(c * 16 + i + 1), 128'(i), 1'(i % 2), 3'(i));
      req_vld = '1;
      sample();
      chk("t2_grant", req_rdy, 4'b0001 << (c % 4));
    end
    for (int c = 8; c <= 20; c++) begin
      next_cycle();
      req_vld = '0;
      sample();
      if (c >= 13) chk("t2_rsp_order", rsp_vld, 4'b0001 << ((c - 13) % 4));
    end
    drain();

    // stall: req 2 result held while rsp_rdy[2]=0 for 5 cycles
    rsp_rdy = 4'b1011;
    set_op(2, 128'd100, 128'd1, 1'b1, 3'b000);
    req_vld = 4'b0100;
    sample();
    chk("t3_rdy_c0", req_rdy, 4'b0100);
    next_cycle();
    set_op(0, 128'd7, 128'd7, 1'b0, 3'b001);
    req_vld = 4'b0001;
    sample();
    chk("t3_rdy_c1", req_rdy, 4'b0001);
    for (int c = 2; c <= 12; c++) begin
      next_cycle();
      req_vld = '0;
    end
    for (int c = 13; c <= 17; c++) begin
      next_cycle();
      req_vld = 4'b0010;
      sample();
      chk("t3_stall_ce", fpu_ce, 1'b0);
      chk("t3_stall_rsp", rsp_vld, 4'b0100);
      chk("t3_stall_rdy", req_rdy, 4'b0000);
      chk("t3_stall_data", rsp_data, 128'd99);
    end
    next_cycle();
    rsp_rdy = '1;
    sample();
    chk("t3_release_rsp", rsp_vld, 4'b0100);
    chk("t3_release_rdy", req_rdy, 4'b0010);
    chk("t3_release_ce", fpu_ce, 1'b1);
    next_cycle();
    req_vld = '0;
    sample();
    chk("t3_next_rsp", rsp_vld, 4'b0001);
    chk("t3_next_data", rsp_data, 128'd14);
    drain();

    // reset mid-stream with 6 ops in flight
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle();
      set_op(c % 4, 128'(1000 + c), 128'd1, 1'b0, 3'b000);
      req_vld = '1;
    end
    next_cycle();
    req_vld = '0;
    next_cycle();
    sample();
    chk("t4_inflight_pre", inflight, 6);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("t4_inflight_now", inflight, 0);
    chk("t4_rsp_vld_now", rsp_vld, 0);
    sample();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      sample();
      chk("t4_no_rsp", rsp_vld, 0);
      next_cycle();
    end

    // sparse: req 3, then req 1, then all -> pointer has moved to 2
    set_op(3, 128'd40, 128'd2, 1'b1, 3'b100);
    req_vld = 4'b1000;
    sample();
    chk("t5_grant3", req_rdy, 4'b1000);
    next_cycle();
    set_op(1, 128'd9, 128'd9, 1'b0, 3'b011);
    req_vld = 4'b0010;
    sample();
    chk("t5_grant1", req_rdy, 4'b0010);
    next_cycle();
    req_vld = '1;
    sample();
    chk("t5_ptr2", req_rdy, 4'b0100);
    drain();

    // random traffic with occasional back-pressure
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++) begin
        rsp_rdy[i] = ($urandom_range(0, 9) < 8);
        set_op(i, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end
    end
    drain();
    sample();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
